alu_arbiter: RTL and testbench

- Shares one combinational RV ALU instance between NUM_REQ requesters (e.g. integer pipe, branch unit, AGU, debug port).
- Arbitration is round-robin. The arbiter drives the ALU with the granted request and captures result/zero into a small response FIFO, tagged with the requester id.
- Both sides use valid/ready handshakes, so the ALU, a single-cycle resource, is time-multiplexed without starving any requester.

---
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-multiplexes one combinational ALU between NUM_REQ
// requesters and queues each result, tagged with its requester id, in a small FIFO.
module alu_arbiter #(
    parameter int  NUM_REQ   = 4,
    parameter int  RSP_DEPTH = 2,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*4-1:0]    req_op,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic [3:0]              alu_op,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    input  logic [31:0]             alu_result,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    rsp_zero
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic [3:0]       op_arr [NUM_REQ];
    logic [31:0]      a_arr  [NUM_REQ];
    logic [31:0]      b_arr  [NUM_REQ];

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  cand;
    logic             have_winner;
    logic             can_accept;
    logic             push;
    logic             pop;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  mem_id     [RSP_DEPTH];
    logic [31:0]      mem_result [RSP_DEPTH];
    logic             mem_zero   [RSP_DEPTH];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[4*i +: 4];
        assign a_arr[i]  = req_a[32*i +: 32];
        assign b_arr[i]  = req_b[32*i +: 32];
    end

    // A slot freed by this cycle's pop is deliberately not reused until the next cycle.
    assign can_accept = (count != CNT_W'(RSP_DEPTH));

    // Scan from the farthest candidate back toward rr_ptr so the nearest valid one wins.
    always_comb begin
        have_winner = 1'b0;
        winner      = '0;
        cand        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                have_winner = 1'b1;
                winner      = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (have_winner && rst_n)
            req_ready[winner] = can_accept;
    end

    always_comb begin
        alu_op = 4'b0000;
        alu_a  = '0;
        alu_b  = '0;
        if (have_winner) begin
            alu_op = op_arr[winner];
            alu_a  = a_arr[winner];
            alu_b  = b_arr[winner];
        end
    end

    assign push      = |(req_valid & req_ready);
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    // Head of the FIFO comes straight from storage, isolating rsp_* from the request side.
    assign rsp_id     = mem_id[rd_ptr];
    assign rsp_result = mem_result[rd_ptr];
    assign rsp_zero   = mem_zero[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_id[i]     <= '0;
                mem_result[i] <= '0;
                mem_zero[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_id[wr_ptr]     <= winner;
                mem_result[wr_ptr] <= alu_result;
                mem_zero[wr_ptr]   <= alu_zero;
                wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop and a scoreboard
// queue holds the response expected for every accepted request.
module tb_alu_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int RSP_DEPTH = 2;
    localparam int ID_W      = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     result;
        logic            zero;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*4-1:0]  req_op;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [3:0]            alu_op;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [31:0]           alu_result;
    logic                  alu_zero;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_zero;

    logic [3:0]  tb_op [NUM_REQ];
    logic [31:0] tb_a  [NUM_REQ];
    logic [31:0] tb_b  [NUM_REQ];

    rsp_t        exp_q[$];
    int          grant_log[$];
    logic [31:0] popped_q[$];
    int          total;
    int          bad;
    bit          auto_drop;
    int          rr_exp[5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_op[4*g +: 4]  = tb_op[g];
        assign req_a[32*g +: 32] = tb_a[g];
        assign req_b[32*g +: 32] = tb_b[g];
    end

    // Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, anything else yields 0.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return {31'd0, ($signed(a) < $signed(b))};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'd0);

    alu_arbiter #(.NUM_REQ(NUM_REQ), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int i, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
        tb_op[i]     = op;
        tb_a[i]      = a;
        tb_b[i]      = b;
        req_valid[i] = 1'b1;
    endtask

    // One clock: observe pops and accepts mid-cycle, then return just after the next edge.
    task automatic tick();
        rsp_t               e;
        logic [NUM_REQ-1:0] acc;
        logic [31:0]        r;
        @(negedge clk);
        check_output("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (rsp_valid && rsp_ready) begin
            popped_q.push_back(rsp_result);
            if (exp_q.size() == 0) begin
                check_output("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("sb_id", 32'(rsp_id), 32'(e.id));
                check_output("sb_result", rsp_result, e.result);
                check_output("sb_zero", 32'(rsp_zero), 32'(e.zero));
            end
        end
        acc = req_valid & req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                r        = alu_model(tb_op[i], tb_a[i], tb_b[i]);
                e.id     = ID_W'(i);
                e.result = r;
                e.zero   = (r == 32'd0);
                exp_q.push_back(e);
                grant_log.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        if (auto_drop)
            req_valid = req_valid & ~acc;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        exp_q.delete();
        grant_log.delete();
        popped_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int k = 0; k < 16 && exp_q.size() > 0; k++)
            tick();
        check_output("drain_empty", 32'(exp_q.size()), 32'd0);
        check_output("drain_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        auto_drop = 1'b1;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tb_op[i] = 4'hA;
            tb_a[i]  = 32'hDEAD_0000 + 32'(i);
            tb_b[i]  = 32'hBEEF_0000 + 32'(i);
        end

        // Reset and idle: operands present but nobody valid.
        @(posedge clk);
        #1;
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_output("rst_rsp_result", rsp_result, 32'd0);
        check_output("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        req_valid = 4'b1111;
        #1;
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        #1;
        check_output("idle_req_ready", 32'(req_ready), 32'd0);
        check_output("idle_alu_op", 32'(alu_op), 32'd0);
        check_output("idle_alu_a", alu_a, 32'd0);
        check_output("idle_alu_b", alu_b, 32'd0);
        tick();
        check_output("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Single ADD from requester 2.
        rsp_ready = 1'b1;
        apply_stimulus(2, 4'd0, 32'd7, 32'd5);
        #1;
        check_output("single_ready", 32'(req_ready), 32'b0100);
        check_output("single_alu_a", alu_a, 32'd7);
        check_output("single_alu_b", alu_b, 32'd5);
        tick();
        check_output("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("single_rsp_id", 32'(rsp_id), 32'd2);
        check_output("single_rsp_result", rsp_result, 32'd12);
        check_output("single_rsp_zero", 32'(rsp_zero), 32'd0);
        tick();
        check_output("single_drained", 32'(rsp_valid), 32'd0);

        // Round-robin: everyone continuously requesting SUB a=i b=i.
        do_reset();
        auto_drop = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++)
            apply_stimulus(i, 4'd1, 32'(i), 32'(i));
        repeat (5) tick();
        check_output("rr_accepts", 32'(grant_log.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            check_output("rr_order", 32'(grant_log[k]), 32'(rr_exp[k]));
        check_output("rr_head_result", rsp_result, 32'd0);
        check_output("rr_head_zero", 32'(rsp_zero), 32'd1);
        req_valid = '0;
        auto_drop = 1'b1;
        drain();

        // Backpressure: fill both slots, pop once, then refill.
        do_reset();
        auto_drop = 1'b0;
        apply_stimulus(0, 4'd0, 32'd100, 32'd1);
        apply_stimulus(1, 4'd0, 32'd200, 32'd1);
        tick();
        tick();
        check_output("bp_two_accepts", 32'(grant_log.size()), 32'd2);
        check_output("bp_full_ready", 32'(req_ready), 32'd0);
        check_output("bp_head_id", 32'(rsp_id), 32'd0);
        check_output("bp_head_result", rsp_result, 32'd101);
        rsp_ready = 1'b1;
        #1;
        check_output("bp_pop_cycle_ready", 32'(req_ready), 32'd0);
        tick();
        check_output("bp_no_push_on_pop", 32'(grant_log.size()), 32'd2);
        rsp_ready = 1'b0;
        #1;
        check_output("bp_after_pop_ready", 32'(req_ready), 32'b0001);
        tick();
        check_output("bp_refill_count", 32'(grant_log.size()), 32'd3);
        check_output("bp_refill_id", 32'(grant_log[2]), 32'd0);

        // Reset with a full FIFO: response side must drop at once.
        rst_n = 1'b0;
        #1;
        check_output("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("midrst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        grant_log.delete();
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        #1;
        check_output("midrst_rr_cleared", 32'(req_ready), 32'b0001);
        check_output("midrst_empty", 32'(rsp_valid), 32'd0);
        req_valid = '0;

        // Wrap-around: ten ORs while the consumer toggles readiness.
        do_reset();
        auto_drop = 1'b1;
        for (int n = 0; n < 10; n++) begin
            apply_stimulus(n % 4, 4'd3, 32'(n), 32'h100);
            for (int k = 0; k < 20 && req_valid[n % 4]; k++) begin
                rsp_ready = ~rsp_ready;
                tick();
            end
            if (req_valid[n % 4]) begin
                check_output("wrap_accept_timeout", 32'(req_valid[n % 4]), 32'd0);
                req_valid[n % 4] = 1'b0;
            end
        end
        check_output("wrap_accepts", 32'(grant_log.size()), 32'd10);
        drain();
        check_output("wrap_pops", 32'(popped_q.size()), 32'd10);
        for (int n = 0; n < 10; n++)
            check_output("wrap_result", popped_q[n], 32'h100 | 32'(n));

        // Signed compare and an unused op code from requester 3.
        rsp_ready = 1'b1;
        apply_stimulus(3, 4'd5, 32'hFFFF_FFFF, 32'd1);
        tick();
        check_output("slt_rsp_id", 32'(rsp_id), 32'd3);
        check_output("slt_rsp_result", rsp_result, 32'd1);
        check_output("slt_rsp_zero", 32'(rsp_zero), 32'd0);
        apply_stimulus(3, 4'hF, 32'd123, 32'd456);
        tick();
        check_output("opf_rsp_id", 32'(rsp_id), 32'd3);
        check_output("opf_rsp_result", rsp_result, 32'd0);
        check_output("opf_rsp_zero", 32'(rsp_zero), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
